// File: rtl/scc_pkg.sv
// Shared SCC core types and defaults: IF/ID bundle, error-flag bit positions,
// fetch defaults and a saturating counter helper.
package scc_pkg;

    localparam logic [31:0] SCC_RESET_PC    = 32'h0000_0000;
    localparam logic [7:0]  SCC_HALT_OPCODE = 8'hFF;
    localparam int unsigned SCC_PC_STEP     = 4;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_PCWRAP   = 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } ifid_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/scc_fetch_ifid_if.sv
// Fetch-stage bus: pipeline control in, instruction memory, IF/ID view to decode.
// Perf counter signals exist only when SCC_FETCH_PERF_EN is defined.
interface scc_fetch_ifid_if;

    logic        clk_en;
    logic        stall;
    logic        flush;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic [31:0] instruction_memory_a;
    logic        instruction_memory_en;
    logic [31:0] instruction_memory_v;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic        ifid_valid;
    logic        halt_f;
    logic [1:0]  err_bits;
`ifdef SCC_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;

    modport master (
        input  clk_en, stall, flush, redirect_en, redirect_pc, instruction_memory_v,
        output instruction_memory_a, instruction_memory_en,
        output ifid_instr, ifid_pc, ifid_valid, halt_f, err_bits,
        output perf_fetch_cnt, perf_stall_cnt
    );
    modport slave (
        output clk_en, stall, flush, redirect_en, redirect_pc, instruction_memory_v,
        input  instruction_memory_a, instruction_memory_en,
        input  ifid_instr, ifid_pc, ifid_valid, halt_f, err_bits,
        input  perf_fetch_cnt, perf_stall_cnt
    );
`else
    modport master (
        input  clk_en, stall, flush, redirect_en, redirect_pc, instruction_memory_v,
        output instruction_memory_a, instruction_memory_en,
        output ifid_instr, ifid_pc, ifid_valid, halt_f, err_bits
    );
    modport slave (
        output clk_en, stall, flush, redirect_en, redirect_pc, instruction_memory_v,
        input  instruction_memory_a, instruction_memory_en,
        input  ifid_instr, ifid_pc, ifid_valid, halt_f, err_bits
    );
`endif

endinterface

// File: rtl/scc_pc_reg.sv
// Program counter with priority next-PC selection (halt > redirect > stall > advance)
// and sticky misaligned-redirect / PC-wrap error flags.
module scc_pc_reg
    import scc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = SCC_RESET_PC,
    parameter int unsigned PC_STEP  = SCC_PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic        halted,
    input  logic        stall,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [1:0]  err_bits
);

    logic [31:0] pc_q, pc_d;
    logic [1:0]  err_q, err_d;
    logic [32:0] pc_inc;

    always_comb begin
        pc_inc = {1'b0, pc_q} + 33'(PC_STEP);
        pc_d   = pc_q;
        err_d  = err_q;
        if (clk_en && !halted) begin
            if (redirect_en) begin
                pc_d = {redirect_pc[31:2], 2'b00};
                if (|redirect_pc[1:0]) err_d[ERR_MISALIGN] = 1'b1;
            end else if (!stall) begin
                // Flush and normal fetch both advance; carry-out means the PC wrapped.
                pc_d = pc_inc[31:0];
                if (pc_inc[32]) err_d[ERR_PCWRAP] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            err_q <= '0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    assign pc       = pc_q;
    assign err_bits = err_q;

endmodule

// File: rtl/scc_fetch_ifid.sv
// SCC instruction fetch stage and IF/ID register with stall/flush/redirect/halt.
// Optional perf counters are enabled with macro SCC_FETCH_PERF_EN.
module scc_fetch_ifid
    import scc_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = SCC_RESET_PC,
    parameter logic [7:0]  HALT_OPCODE = SCC_HALT_OPCODE,
    parameter int unsigned PC_STEP     = SCC_PC_STEP
) (
    input  logic             clk,
    input  logic             rst,
    scc_fetch_ifid_if.master bus
);

    ifid_t       ifid_q, ifid_d;
    logic        halt_q, halt_d;
    logic        capture;
    logic [31:0] pc;
    logic [1:0]  err_bits;

    scc_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (bus.clk_en),
        .halted      (halt_q),
        .stall       (bus.stall),
        .redirect_en (bus.redirect_en),
        .redirect_pc (bus.redirect_pc),
        .pc          (pc),
        .err_bits    (err_bits)
    );

    always_comb begin
        ifid_d  = ifid_q;
        halt_d  = halt_q;
        capture = 1'b0;
        if (bus.clk_en) begin
            if (halt_q || bus.redirect_en) begin
                // A HALT word arriving alongside a redirect is on the wrong path.
                ifid_d.valid = 1'b0;
            end else if (bus.stall) begin
                if (bus.flush) ifid_d.valid = 1'b0;
            end else if (bus.flush) begin
                ifid_d.valid = 1'b0;
            end else begin
                capture = 1'b1;
                ifid_d  = '{instr: bus.instruction_memory_v, pc: pc, valid: 1'b1};
                if (bus.instruction_memory_v[31:24] == HALT_OPCODE) halt_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ifid_q <= '0;
            halt_q <= 1'b0;
        end else begin
            ifid_q <= ifid_d;
            halt_q <= halt_d;
        end
    end

    assign bus.instruction_memory_a  = pc;
    assign bus.instruction_memory_en = !halt_q;
    assign bus.ifid_instr            = ifid_q.instr;
    assign bus.ifid_pc               = ifid_q.pc;
    assign bus.ifid_valid            = ifid_q.valid;
    assign bus.halt_f                = halt_q;
    assign bus.err_bits              = err_bits;

`ifdef SCC_FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt_q, perf_fetch_cnt_d;
    logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

    always_comb begin
        perf_fetch_cnt_d = perf_fetch_cnt_q;
        perf_stall_cnt_d = perf_stall_cnt_q;
        if (capture) perf_fetch_cnt_d = sat_inc32(perf_fetch_cnt_q);
        if (bus.clk_en && bus.stall && !halt_q && !bus.redirect_en)
            perf_stall_cnt_d = sat_inc32(perf_stall_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt_q <= '0;
            perf_stall_cnt_q <= '0;
        end else begin
            perf_fetch_cnt_q <= perf_fetch_cnt_d;
            perf_stall_cnt_q <= perf_stall_cnt_d;
        end
    end

    assign bus.perf_fetch_cnt = perf_fetch_cnt_q;
    assign bus.perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule

// File: doc/scc_fetch_ifid.md
Name: scc_fetch_ifid

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the SCC core.
- Owns the program counter and drives the instruction-memory address/enable; sits directly upstream of the scc decode logic.
- Captures the fetched word into the IF/ID register, and handles stall, flush, branch redirect and halt detection.
- Replaces the PC register currently held inside scc and feeds instruction_memory_v/ifid fields to decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_OPCODE, 8'hFF, value of instruction[31:24] that identifies HALT.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- clk_en  in  1  global advance enable; 0 = every register holds
- stall  in  1  decode hazard; hold PC and IF/ID contents
- flush  in  1  invalidate IF/ID at next edge
- redirect_en  in  1  branch/jump taken; load redirect_pc
- redirect_pc  in  32  redirect target byte address
- instruction_memory_a  out  32  fetch address (= pc register)
- instruction_memory_en  out  1  fetch request; 0 once halted
- instruction_memory_v  in  32  fetched word; memory samples on negedge, so valid before next posedge
- ifid_instr  out  32  registered instruction to decode
- ifid_pc  out  32  PC of ifid_instr
- ifid_valid  out  1  ifid_instr is live
- halt_f  out  1  sticky; HALT has been captured into IF/ID
- err_bits  out  2  sticky error flags: [0] misaligned redirect, [1] PC wrap

Behaviour:
- Reset (rst=1 at edge, overrides clk_en): pc=RESET_PC, ifid_instr=0, ifid_pc=0, ifid_valid=0, halt_f=0, err_bits=0.
- instruction_memory_a = pc (combinational from register).
- instruction_memory_en = !halt_f.
- Latency: the word at pc appears on ifid_instr one rising edge later; throughput is 1 instruction per cycle.
- Per-edge priority (clk_en=1, rst=0): halted > redirect > stall > flush > normal.
- Halted (halt_f=1): pc holds; ifid_valid<=0; ifid_instr/ifid_pc hold; redirect, stall and flush are ignored.
- Redirect: pc <= {redirect_pc[31:2],2'b00}; ifid_valid<=0. Wins over a simultaneous stall or flush.
  - If redirect_pc[1:0]!=0, err_bits[0]<=1.
  - A HALT at IF in the same cycle is discarded; halt_f does not set.
- Stall (no redirect): pc and all ifid_* hold. A simultaneous flush also forces ifid_valid<=0.
- Flush only: ifid_valid<=0; pc <= pc+PC_STEP.
- Normal: ifid_instr<=instruction_memory_v; ifid_pc<=pc; ifid_valid<=1; pc<=pc+PC_STEP.
  - If instruction_memory_v[31:24]==HALT_OPCODE: halt_f<=1 and the HALT word itself is captured with ifid_valid=1.
- PC arithmetic is 32-bit modulo. If pc==32'hFFFF_FFFC when advancing, pc wraps to 0 and err_bits[1]<=1.
- clk_en=0: no state changes (including error and halt flags); outputs hold.
- Reset mid-operation (e.g. while halted or stalled): returns to reset state at that edge; fetch resumes from RESET_PC the following cycle.

Optional Feature:
- Macro SCC_FETCH_PERF_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_fetch_cnt increments on every edge that sets ifid_valid=1.
  - perf_stall_cnt increments on every edge with clk_en&stall&!halt_f&!redirect_en.
  - Both reset to 0, saturate at 32'hFFFF_FFFF and hold when clk_en=0.
- Not defined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package scc_pkg holds:
  - RESET_PC and HALT_OPCODE defaults;
  - localparam ERR_MISALIGN=0, ERR_PCWRAP=1;
  - typedef of the IF/ID bundle struct {instr, pc, valid}, reusable by the ID/EX register.
- One natural sub-module, scc_pc_reg: PC register with priority-mux next-PC logic and wrap/misalign detection.
- The IF/ID register and halt logic stay in the parent.

Test Plan:
1. Reset, then 4 cycles of normal fetch with memory returning 32'h1000_0001+addr → ifid_pc=0,4,8,C in turn; ifid_valid=1 from cycle 1; instruction_memory_a=0x10 after 4 edges.
2. stall=1 for 2 cycles at pc=8 → ifid_pc stays 4 and pc stays 8; same cycle stall+flush → ifid_valid=0, pc=8.
3. redirect_en=1, redirect_pc=0x42 with stall=1 → pc=0x40, ifid_valid=0, err_bits=2'b01.
4. Memory returns 32'hFF00_0000 at pc=0x20 → next edge ifid_instr=FF000000, ifid_valid=1, halt_f=1; then instruction_memory_en=0, ifid_valid=0, pc frozen at 0x24, a later redirect ignored.
5. HALT word at IF together with redirect_en → halt_f stays 0, pc=target; force pc=FFFFFFFC and advance → pc=0, err_bits[1]=1.
6. clk_en=0 for 3 cycles mid-stream → all outputs frozen; rst=1 while halted → all outputs at reset values, fetch restarts at RESET_PC.
